// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage pipeline: stall, bubble, flush and EX forwarding selects.
// Optional operand forwarding is enabled by defining PIPE_FORWARD_EN.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr_in,
  input  logic             branch_taken_in,
  output logic             stall_out,
  output logic             bubble_out,
  output logic             flush_out,
  output logic [1:0]       fwd_rs_sel_out,
  output logic [1:0]       fwd_rt_sel_out,
  output logic [CNT_W-1:0] stall_cnt_out
);

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       is_load;
  } slot_t;

  typedef enum logic {RUN, STALL} state_t;

  state_t     state;
  logic [1:0] cnt;
  slot_t      slot_ex, slot_mem, slot_wb, dec;
  logic [5:0] op;
  logic [4:0] rs, rt, rd;
  logic       rs_use, rt_use;
  logic       rs_ex, rt_ex, rs_mem, rt_mem;
  logic       hazard;
  logic [1:0] need;
  logic [1:0] sel_rs, sel_rt;

  assign op = instr_in[31:26];
  assign rs = instr_in[25:21];
  assign rt = instr_in[20:16];
  assign rd = instr_in[15:11];

  always_comb begin
    rs_use = 1'b0;
    rt_use = 1'b0;
    dec    = '0;
    case (op)
      6'h00: begin
        rs_use = 1'b1; rt_use = 1'b1;
        dec.valid = 1'b1; dec.dst = rd;
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D: begin
        rs_use = 1'b1;
        dec.valid = 1'b1; dec.dst = rt;
      end
      6'h23: begin
        rs_use = 1'b1;
        dec.valid = 1'b1; dec.dst = rt; dec.is_load = 1'b1;
      end
      6'h2B, 6'h04, 6'h05: begin
        rs_use = 1'b1; rt_use = 1'b1;
      end
      default: ;
    endcase
    // $0 is hardwired, so it neither produces nor consumes a dependency
    if (dec.dst == 5'd0) dec.valid = 1'b0;
  end

  function automatic logic hit(slot_t s, logic use_src, logic [4:0] r);
    return s.valid && use_src && (r != 5'd0) && (s.dst == r);
  endfunction

  assign rs_ex  = hit(slot_ex,  rs_use, rs);
  assign rt_ex  = hit(slot_ex,  rt_use, rt);
  assign rs_mem = hit(slot_mem, rs_use, rs);
  assign rt_mem = hit(slot_mem, rt_use, rt);

`ifdef PIPE_FORWARD_EN
  assign hazard = slot_ex.is_load && (rs_ex || rt_ex);
  assign need   = 2'd0;
  assign sel_rs = rs_ex ? 2'b01 : (rs_mem ? 2'b10 : 2'b00);
  assign sel_rt = rt_ex ? 2'b01 : (rt_mem ? 2'b10 : 2'b00);
`else
  // youngest producer sets the stall length: EX needs 2 cycles, MEM needs 1
  assign hazard = rs_ex || rt_ex || rs_mem || rt_mem;
  assign need   = (rs_ex || rt_ex) ? 2'd1 : 2'd0;
  assign sel_rs = 2'b00;
  assign sel_rt = 2'b00;
`endif

  always_comb begin
    stall_out  = 1'b0;
    bubble_out = 1'b0;
    flush_out  = 1'b0;
    if (!rst_n) begin
      stall_out  = 1'b0;
    end else if (branch_taken_in) begin
      flush_out  = 1'b1;
      bubble_out = 1'b1;
    end else if (state == STALL || hazard) begin
      stall_out  = 1'b1;
      bubble_out = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= RUN;
      cnt            <= 2'd0;
      slot_ex        <= '0;
      slot_mem       <= '0;
      slot_wb        <= '0;
      fwd_rs_sel_out <= 2'b00;
      fwd_rt_sel_out <= 2'b00;
      stall_cnt_out  <= '0;
    end else begin
      slot_wb        <= slot_mem;
      slot_mem       <= slot_ex;
      slot_ex        <= bubble_out ? slot_t'('0) : dec;
      fwd_rs_sel_out <= bubble_out ? 2'b00 : sel_rs;
      fwd_rt_sel_out <= bubble_out ? 2'b00 : sel_rt;
      if (stall_out && (stall_cnt_out != '1))
        stall_cnt_out <= stall_cnt_out + {{(CNT_W-1){1'b0}}, 1'b1};
      if (branch_taken_in) begin
        state <= RUN;
        cnt   <= 2'd0;
      end else if (state == RUN) begin
        if (hazard) begin
          cnt   <= need;
          state <= (need != 2'd0) ? STALL : RUN;
        end
      end else begin
        cnt <= cnt - 2'd1;
        if (cnt <= 2'd1) state <= RUN;
      end
    end
  end

  // write-first register file: the WB slot is kept only for completeness
  logic unused_bits;
  assign unused_bits = ^{instr_in[10:0], slot_wb, slot_mem.is_load, slot_ex.is_load};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; expectations follow the PIPE_FORWARD_EN build option.
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        br;
  logic        stall, bubble, flush;
  logic [1:0]  fwd_rs, fwd_rt, s_fwd_rs, s_fwd_rt;
  logic [15:0] cnt;
  logic        s_stall, s_bubble, s_flush;
  logic [1:0]  s_cnt;
  int checks = 0;
  int failures = 0;

  localparam logic [31:0] NOP     = 32'h0;
  localparam logic [31:0] ADD312  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] SUB431  = {6'h00, 5'd3, 5'd1, 5'd4, 5'd0, 6'h22};
  localparam logic [31:0] LW5     = {6'h23, 5'd0, 5'd5, 16'd0};
  localparam logic [31:0] ADD655  = {6'h00, 5'd5, 5'd5, 5'd6, 5'd0, 6'h20};
  localparam logic [31:0] ADDI7   = {6'h08, 5'd0, 5'd7, 16'd1};
  localparam logic [31:0] OR800   = {6'h00, 5'd0, 5'd0, 5'd8, 5'd0, 6'h25};
  localparam logic [31:0] AND977  = {6'h00, 5'd7, 5'd7, 5'd9, 5'd0, 6'h24};
  localparam logic [31:0] OR1099  = {6'h00, 5'd9, 5'd9, 5'd10, 5'd0, 6'h25};
  localparam logic [31:0] ADD012  = {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20};
  localparam logic [31:0] SUB400  = {6'h00, 5'd0, 5'd0, 5'd4, 5'd0, 6'h22};

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr), .branch_taken_in(br),
    .stall_out(stall), .bubble_out(bubble), .flush_out(flush),
    .fwd_rs_sel_out(fwd_rs), .fwd_rt_sel_out(fwd_rt), .stall_cnt_out(cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .instr_in(instr), .branch_taken_in(br),
    .stall_out(s_stall), .bubble_out(s_bubble), .flush_out(s_flush),
    .fwd_rs_sel_out(s_fwd_rs), .fwd_rt_sel_out(s_fwd_rt), .stall_cnt_out(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    instr = NOP;
    repeat (3) nxt();
  endtask

  initial begin
    rst_n = 1'b0; br = 1'b0; instr = SUB431;
    repeat (3) nxt();
    #2;
    chk("rst_stall",  32'(stall),  32'd0);
    chk("rst_bubble", 32'(bubble), 32'd0);
    chk("rst_flush",  32'(flush),  32'd0);
    chk("rst_fwd_rs", 32'(fwd_rs), 32'd0);
    chk("rst_fwd_rt", 32'(fwd_rt), 32'd0);
    chk("rst_cnt",    32'(cnt),    32'd0);
    rst_n = 1'b1;

    // add $3,$1,$2 ; sub $4,$3,$1
    nxt(); instr = ADD312; #2;
    chk("t1_add_stall", 32'(stall), 32'd0);
    nxt(); instr = SUB431; #2;
`ifdef PIPE_FORWARD_EN
    chk("t1_det_stall", 32'(stall), 32'd0);
    nxt();
    chk("t1_fwd_rs", 32'(fwd_rs), 32'd1);
    chk("t1_fwd_rt", 32'(fwd_rt), 32'd0);
`else
    chk("t1_det_stall",  32'(stall),  32'd1);
    chk("t1_det_bubble", 32'(bubble), 32'd1);
    chk("t1_det_flush",  32'(flush),  32'd0);
    nxt(); #2;
    chk("t1_stall2", 32'(stall), 32'd1);
    nxt(); #2;
    chk("t1_release", 32'(stall), 32'd0);
    chk("t1_cnt",     32'(cnt),   32'd2);
    chk("t1_sat_cnt", 32'(s_cnt), 32'd2);
    nxt();
    chk("t1_fwd_rs", 32'(fwd_rs), 32'd0);
`endif
    drain();

    // lw $5,0($0) ; add $6,$5,$5
    instr = LW5; #2;
    chk("t2_lw_stall", 32'(stall), 32'd0);
    nxt(); instr = ADD655; #2;
    chk("t2_det_stall", 32'(stall), 32'd1);
`ifdef PIPE_FORWARD_EN
    nxt(); #2;
    chk("t2_release", 32'(stall), 32'd0);
    nxt();
    chk("t2_fwd_rs", 32'(fwd_rs), 32'd2);
    chk("t2_fwd_rt", 32'(fwd_rt), 32'd2);
    chk("t2_cnt",    32'(cnt),    32'd1);
`else
    nxt(); #2;
    chk("t2_stall2", 32'(stall), 32'd1);
    nxt(); #2;
    chk("t2_release", 32'(stall), 32'd0);
    nxt();
    chk("t2_fwd_rs", 32'(fwd_rs), 32'd0);
    chk("t2_cnt",    32'(cnt),    32'd4);
`endif
    drain();

    // addi $7,$0,1 ; or $8,$0,$0 ; and $9,$7,$7 ; or $10,$9,$9
    instr = ADDI7;
    nxt(); instr = OR800; #2;
    chk("t3_or_stall", 32'(stall), 32'd0);
    nxt(); instr = AND977; #2;
`ifdef PIPE_FORWARD_EN
    chk("t3_and_stall", 32'(stall), 32'd0);
    nxt(); instr = OR1099;
    chk("t3_and_fwd_rs", 32'(fwd_rs), 32'd2);
    chk("t3_and_fwd_rt", 32'(fwd_rt), 32'd2);
    #2;
    chk("t3_dep_stall", 32'(stall), 32'd0);
    nxt();
    chk("t3_dep_fwd_rs", 32'(fwd_rs), 32'd1);
    chk("t3_dep_fwd_rt", 32'(fwd_rt), 32'd1);
`else
    chk("t3_and_stall", 32'(stall), 32'd1);
    nxt(); #2;
    chk("t3_and_release", 32'(stall), 32'd0);
    nxt(); instr = OR1099;
    chk("t3_and_fwd_rs", 32'(fwd_rs), 32'd0);
    #2;
    chk("t3_dep_stall", 32'(stall), 32'd1);
    nxt(); #2;
    chk("t3_dep_stall2", 32'(stall), 32'd1);
    nxt(); #2;
    chk("t3_dep_release", 32'(stall), 32'd0);
    chk("t3_cnt",         32'(cnt),   32'd7);
    chk("t3_sat_cnt",     32'(s_cnt), 32'd3);
    nxt();
`endif
    drain();

    // taken branch in the hazard-detecting cycle
    instr = LW5;
    nxt(); instr = ADD655; br = 1'b1; #2;
    chk("t4_flush",  32'(flush),  32'd1);
    chk("t4_bubble", 32'(bubble), 32'd1);
    chk("t4_stall",  32'(stall),  32'd0);
    nxt(); br = 1'b0; instr = NOP;
    chk("t4_fwd_rs", 32'(fwd_rs), 32'd0);
    #2;
    chk("t4_after_stall", 32'(stall), 32'd0);
    chk("t4_after_flush", 32'(flush), 32'd0);
`ifdef PIPE_FORWARD_EN
    chk("t4_cnt", 32'(cnt), 32'd1);
`else
    chk("t4_cnt", 32'(cnt), 32'd7);
    // taken branch while already in the STALL state
    drain();
    instr = ADD312;
    nxt(); instr = SUB431; #2;
    chk("t4b_det_stall", 32'(stall), 32'd1);
    nxt(); br = 1'b1; #2;
    chk("t4b_stall", 32'(stall), 32'd0);
    chk("t4b_flush", 32'(flush), 32'd1);
    chk("t4b_bubble", 32'(bubble), 32'd1);
    nxt(); br = 1'b0; instr = NOP; #2;
    chk("t4b_run", 32'(stall), 32'd0);
    chk("t4b_cnt", 32'(cnt),   32'd8);
`endif
    drain();

    // $0 destination never creates a dependency
    instr = ADD012;
    nxt(); instr = SUB400; #2;
    chk("t5_stall", 32'(stall), 32'd0);
    nxt(); instr = NOP;
    chk("t5_fwd_rs", 32'(fwd_rs), 32'd0);
    chk("t5_fwd_rt", 32'(fwd_rt), 32'd0);
`ifdef PIPE_FORWARD_EN
    chk("t5_sat_cnt", 32'(s_cnt), 32'd1);
`else
    chk("t5_sat_cnt", 32'(s_cnt), 32'd3);
`endif
    drain();

    // reset in the middle of a stall
    instr = LW5;
    nxt(); instr = ADD655; #2;
    chk("t6_det_stall", 32'(stall), 32'd1);
    rst_n = 1'b0; #1;
    chk("t6_rst_stall", 32'(stall), 32'd0);
    nxt(); rst_n = 1'b1; #2;
    chk("t6_post_stall", 32'(stall), 32'd0);
    chk("t6_post_cnt",   32'(cnt),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
